// File: rtl/i2c_pkg.sv
// Shared I2C definitions: controller state encoding, quarter indices and
// slot-count constants, plus the quarter-period divider helper.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ACK1,
    ST_WR,
    ST_RD,
    ST_ACK2,
    ST_MACK,
    ST_STOP
  } i2c_state_t;

  localparam int unsigned QUARTERS   = 4;
  localparam int unsigned SLOTS_OK   = 20;  // START + 9 + 9 + STOP
  localparam int unsigned SLOTS_NACK = 11;  // START + 9 + STOP

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Quarter-bit period in system clock cycles.
  function automatic int unsigned quarter_div(input int unsigned clk_hz,
                                              input int unsigned scl_hz);
    return clk_hz / (QUARTERS * scl_hz);
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit timebase for the I2C master.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clr          : hold counters at zero (controller idle)
//   o_tick         : high in the last cycle of each quarter
//   o_quarter      : current quarter index q0..q3
module i2c_tick_gen #(
  parameter int unsigned DIV = 125
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  output logic       o_tick,
  output logic [1:0] o_quarter
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_q;
  logic          w_last;

  assign w_last = (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
      r_q   <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
      r_q   <= r_q + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick    = w_last;
  assign o_quarter = r_q;

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, {addr,rw}, ACK, one data byte, ACK/NACK, STOP.
//   sys_clk, rst_n : clock, synchronous active-low reset
//   start, rw, dev_addr, wr_data : command pulse and operands (captured on accept)
//   busy, done, ack_err, rd_data : status / result (done is a one-cycle pulse)
//   scl_oe, sda_oe : open-drain pull-down enables, sda_i : SDA pad level
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned I2C_FREQ = 100_000
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam int unsigned DIV = quarter_div(CLK_FREQ, I2C_FREQ);

  generate
    if (DIV < 2) begin : g_div_chk
      $fatal(1, "i2c_master_ctrl: CLK_FREQ/(4*I2C_FREQ) must be at least 2");
    end
  endgenerate

  i2c_state_t r_state, w_state_nxt;

  logic       w_idle, w_tick, w_slot_end, w_accept, w_scl_nxt;
  logic [1:0] w_q, w_q_nxt;
  logic [2:0] r_bit;
  logic [7:0] r_shift, r_wdata, r_rd_data;
  logic       r_rw, r_err, r_scl_oe, r_sda_oe, r_done, r_ack_err;

  assign w_idle = (r_state == ST_IDLE);

  i2c_tick_gen #(.DIV(DIV)) u_tick (
    .i_clk     (sys_clk),
    .i_rst_n   (rst_n),
    .i_clr     (w_idle),
    .o_tick    (w_tick),
    .o_quarter (w_q)
  );

  assign w_slot_end = w_tick && (w_q == Q3);
  assign w_accept   = start && w_idle;
  assign w_q_nxt    = w_tick ? w_q + 2'd1 : w_q;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_scl_nxt   = 1'b0;
    case (r_state)
      ST_IDLE:  if (start)      w_state_nxt = ST_START;
      ST_START: if (w_slot_end) w_state_nxt = ST_ADDR;
      ST_ADDR:  if (w_slot_end && (r_bit == 3'd7)) w_state_nxt = ST_ACK1;
      ST_ACK1:  if (w_slot_end) w_state_nxt = r_err ? ST_STOP : (r_rw ? ST_RD : ST_WR);
      ST_WR:    if (w_slot_end && (r_bit == 3'd7)) w_state_nxt = ST_ACK2;
      ST_RD:    if (w_slot_end && (r_bit == 3'd7)) w_state_nxt = ST_MACK;
      ST_ACK2:  if (w_slot_end) w_state_nxt = ST_STOP;
      ST_MACK:  if (w_slot_end) w_state_nxt = ST_STOP;
      ST_STOP:  if (w_slot_end) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    // SCL is registered from the next state/quarter so it changes on the same
    // edge a combinational decode of the current state/quarter would.
    case (w_state_nxt)
      ST_IDLE, ST_START: w_scl_nxt = 1'b0;
      default:           w_scl_nxt = ~w_q_nxt[1];
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_bit     <= '0;
      r_shift   <= '0;
      r_wdata   <= '0;
      r_rw      <= 1'b0;
      r_err     <= 1'b0;
      r_scl_oe  <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_done   <= 1'b0;
      r_scl_oe <= w_scl_nxt;
      if (w_accept) begin
        r_shift <= {dev_addr, rw};
        r_wdata <= wr_data;
        r_rw    <= rw;
        r_err   <= 1'b0;
        r_bit   <= '0;
      end
      case (r_state)
        ST_START: if (w_tick && (w_q == Q1)) r_sda_oe <= 1'b1;
        ST_ADDR, ST_WR: begin
          if (w_tick && (w_q == Q0)) r_sda_oe <= ~r_shift[7];
          if (w_slot_end) begin
            r_shift <= {r_shift[6:0], 1'b0};
            r_bit   <= r_bit + 3'd1;
          end
        end
        ST_RD: begin
          if (w_tick && (w_q == Q0)) r_sda_oe <= 1'b0;
          if (w_tick && (w_q == Q2)) r_shift  <= {r_shift[6:0], sda_i};
          if (w_slot_end)            r_bit    <= r_bit + 3'd1;
        end
        ST_ACK1: begin
          if (w_tick && (w_q == Q0)) r_sda_oe <= 1'b0;
          if (w_tick && (w_q == Q2)) r_err    <= sda_i;
          if (w_slot_end)            r_shift  <= r_wdata;
        end
        ST_ACK2: begin
          if (w_tick && (w_q == Q0)) r_sda_oe <= 1'b0;
          if (w_tick && (w_q == Q2)) r_err    <= sda_i;
        end
        ST_MACK: if (w_tick && (w_q == Q0)) r_sda_oe <= 1'b0;
        ST_STOP: begin
          if (w_tick && (w_q == Q2)) r_sda_oe <= 1'b0;
          if (w_slot_end) begin
            r_done    <= 1'b1;
            r_ack_err <= r_err;
            if (!r_err && r_rw) r_rd_data <= r_shift;
          end
        end
        default: ;
      endcase
      // STOP needs SDA low from q0 while SCL is low; set it on slot entry.
      if ((w_state_nxt == ST_STOP) && (r_state != ST_STOP)) r_sda_oe <= 1'b1;
    end
  end

  assign busy    = ~w_idle;
  assign done    = r_done;
  assign ack_err = r_ack_err;
  assign rd_data = r_rd_data;
  assign scl_oe  = r_scl_oe;
  assign sda_oe  = r_sda_oe;

endmodule
